// File: rtl/sched_pkg.sv
// Shared constants, FSM encoding and helpers for the sender scheduler.
package sched_pkg;

    localparam int unsigned NUM_SRC  = 3;

    localparam int unsigned SRC_TIME = 0;
    localparam int unsigned SRC_SR04 = 1;
    localparam int unsigned SRC_DHT  = 2;

    localparam logic [1:0] MODE_WATCH = 2'd0;
    localparam logic [1:0] MODE_SW    = 2'd1;
    localparam logic [1:0] MODE_SR04  = 2'd2;
    localparam logic [1:0] MODE_DHT   = 2'd3;

    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARB       = 2'd1,
        ST_START     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_e;

    // Index of the set bit in a one-hot source vector (source 0 if none set).
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_SRC-1:0] onehot);
        logic [1:0] idx;
        idx = 2'(SRC_TIME);
        if (onehot[SRC_SR04]) begin
            idx = 2'(SRC_SR04);
        end else if (onehot[SRC_DHT]) begin
            idx = 2'(SRC_DHT);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: search starts at the source after last_grant.
module rr_arb3
    import sched_pkg::*;
(
    input  logic [NUM_SRC-1:0] pending,
    input  logic [1:0]         last_grant,
    output logic [NUM_SRC-1:0] grant_c
);

    // Rotate the priority order according to the previous winner.
    always_comb begin
        grant_c = '0;
        case (last_grant)
            2'd0: begin
                if (pending[SRC_SR04])      grant_c[SRC_SR04] = 1'b1;
                else if (pending[SRC_DHT])  grant_c[SRC_DHT]  = 1'b1;
                else if (pending[SRC_TIME]) grant_c[SRC_TIME] = 1'b1;
            end
            2'd1: begin
                if (pending[SRC_DHT])       grant_c[SRC_DHT]  = 1'b1;
                else if (pending[SRC_TIME]) grant_c[SRC_TIME] = 1'b1;
                else if (pending[SRC_SR04]) grant_c[SRC_SR04] = 1'b1;
            end
            default: begin
                if (pending[SRC_TIME])      grant_c[SRC_TIME] = 1'b1;
                else if (pending[SRC_SR04]) grant_c[SRC_SR04] = 1'b1;
                else if (pending[SRC_DHT])  grant_c[SRC_DHT]  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sender_scheduler.sv
// Shares one ASCII line sender between time, SR04 and DHT11 report sources.
module sender_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned PERIOD_MS   = 1000,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  i_req,
    input  logic                i_time_mode,
    input  logic [31:0]         i_time_data,
    input  logic [31:0]         i_sr04_data,
    input  logic [31:0]         i_dht_data,
    input  logic                i_auto_en,
    input  logic [NUM_SRC-1:0]  i_auto_mask,
    input  logic                i_tx_ready,
    input  logic                i_send_valid,
    input  logic [7:0]          i_send_data,
    output logic [1:0]          o_c_mode,
    output logic                o_start,
    output logic [31:0]         o_dec_data,
    output logic [NUM_SRC-1:0]  o_grant,
    output logic                o_busy,
    output logic                o_timeout
);

    localparam int unsigned PRE_DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
    localparam int unsigned PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int unsigned MS_W    = (PERIOD_MS > 1) ? $clog2(PERIOD_MS) : 1;
    localparam int unsigned TO_MAX  = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC : 1;
    localparam int unsigned TO_W    = $clog2(TO_MAX + 1);

    logic [PRE_W-1:0]   pre_cnt;
    logic [MS_W-1:0]    ms_cnt;
    logic               pre_wrap_c;
    logic               ms_wrap_c;
    logic               tick_c;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] set_c;
    logic [NUM_SRC-1:0] clr_c;
    logic [NUM_SRC-1:0] arb_grant_c;
    logic               eof_c;

    sched_state_e       state;
    sched_state_e       state_next;
    logic [1:0]         last_grant;
    logic [1:0]         last_grant_next;
    logic [TO_W-1:0]    to_cnt;
    logic [TO_W-1:0]    to_cnt_next;
    logic [1:0]         c_mode_next;
    logic               start_next;
    logic [31:0]        dec_data_next;
    logic [NUM_SRC-1:0] grant_next;
    logic               busy_next;
    logic               timeout_next;

    assign pre_wrap_c = (pre_cnt == PRE_W'(PRE_DIV - 1));
    assign ms_wrap_c  = (ms_cnt == MS_W'(PERIOD_MS - 1));
    assign tick_c     = (PERIOD_MS != 0) && i_auto_en && pre_wrap_c && ms_wrap_c;

    // Free-running ms prescaler and ms counter; the enable only gates the tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else begin
            pre_cnt <= pre_wrap_c ? '0 : pre_cnt + PRE_W'(1);
            if (pre_wrap_c) begin
                ms_cnt <= ms_wrap_c ? '0 : ms_cnt + MS_W'(1);
            end
        end
    end

    assign set_c = i_req | (tick_c ? i_auto_mask : '0);

    // Pending requests; a new set beats the grant clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_c) | set_c;
        end
    end

    rr_arb3 u_arb (
        .pending    (pending),
        .last_grant (last_grant),
        .grant_c    (arb_grant_c)
    );

    assign eof_c = i_send_valid && (i_send_data == ASCII_LF);

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        to_cnt_next     = to_cnt;
        c_mode_next     = o_c_mode;
        start_next      = 1'b0;
        dec_data_next   = o_dec_data;
        grant_next      = o_grant;
        busy_next       = o_busy;
        timeout_next    = 1'b0;
        clr_c           = '0;
        case (state)
            ST_IDLE: begin
                if (pending != '0) begin
                    state_next = ST_ARB;
                    busy_next  = 1'b1;
                end
            end
            ST_ARB: begin
                clr_c       = arb_grant_c;
                grant_next  = arb_grant_c;
                to_cnt_next = '0;
                state_next  = ST_START;
                if (arb_grant_c[SRC_TIME]) begin
                    c_mode_next   = {1'b0, i_time_mode};
                    dec_data_next = i_time_data;
                end else if (arb_grant_c[SRC_SR04]) begin
                    c_mode_next   = MODE_SR04;
                    dec_data_next = i_sr04_data;
                end else if (arb_grant_c[SRC_DHT]) begin
                    c_mode_next   = MODE_DHT;
                    dec_data_next = i_dht_data;
                end
            end
            ST_START: begin
                if (i_tx_ready) begin
                    start_next = 1'b1;
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (eof_c) begin
                    state_next      = ST_IDLE;
                    grant_next      = '0;
                    busy_next       = 1'b0;
                    last_grant_next = onehot_to_idx(o_grant);
                end else if (i_tx_ready) begin
                    if (to_cnt == TO_W'(TO_MAX - 1)) begin
                        timeout_next    = 1'b1;
                        state_next      = ST_IDLE;
                        grant_next      = '0;
                        busy_next       = 1'b0;
                        last_grant_next = onehot_to_idx(o_grant);
                    end else begin
                        to_cnt_next = to_cnt + TO_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= 2'(SRC_DHT);
            to_cnt     <= '0;
            o_c_mode   <= '0;
            o_start    <= 1'b0;
            o_dec_data <= '0;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            to_cnt     <= to_cnt_next;
            o_c_mode   <= c_mode_next;
            o_start    <= start_next;
            o_dec_data <= dec_data_next;
            o_grant    <= grant_next;
            o_busy     <= busy_next;
            o_timeout  <= timeout_next;
        end
    end

endmodule

// File: tb/tb_sender_scheduler.sv
// Directed bench for sender_scheduler with a simple line-sender model.
module tb_sender_scheduler;

    localparam int NB = 3;

    typedef struct {
        logic [2:0]  req;
        logic        time_mode;
        logic [31:0] time_d;
        logic [31:0] sr04_d;
        logic [31:0] dht_d;
        logic [2:0]  exp_grant;
        logic [1:0]  exp_mode;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [2:0]  i_req;
    logic        i_time_mode;
    logic [31:0] i_time_data;
    logic [31:0] i_sr04_data;
    logic [31:0] i_dht_data;
    logic        i_auto_en;
    logic [2:0]  i_auto_mask;
    logic        i_tx_ready;
    logic        i_send_valid = 1'b0;
    logic [7:0]  i_send_data = 8'h00;
    logic [1:0]  o_c_mode;
    logic        o_start;
    logic [31:0] o_dec_data;
    logic [2:0]  o_grant;
    logic        o_busy;
    logic        o_timeout;

    int unsigned passed = 0;
    int unsigned total = 0;
    int          cyc = 0;
    int          lf_cyc = 0;
    int          rem = 0;
    bit          lf_en = 1'b1;
    vec_t        vecs [4];

    sender_scheduler #(
        .CLK_HZ      (10_000),
        .PERIOD_MS   (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_time_mode  (i_time_mode),
        .i_time_data  (i_time_data),
        .i_sr04_data  (i_sr04_data),
        .i_dht_data   (i_dht_data),
        .i_auto_en    (i_auto_en),
        .i_auto_mask  (i_auto_mask),
        .i_tx_ready   (i_tx_ready),
        .i_send_valid (i_send_valid),
        .i_send_data  (i_send_data),
        .o_c_mode     (o_c_mode),
        .o_start      (o_start),
        .o_dec_data   (o_dec_data),
        .o_grant      (o_grant),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Remember the cycle at which the DUT sampled each LF.
    always @(posedge clk) begin
        if (rst && i_send_valid && i_send_data == 8'h0A) lf_cyc = cyc;
    end

    // Sender model: after start, NB payload bytes then LF, one per ready cycle.
    always @(negedge clk) begin
        if (!rst) begin
            rem = 0;
            i_send_valid = 1'b0;
            i_send_data = 8'h00;
        end else begin
            if (o_start && lf_en) rem = NB + 1;
            if (rem > 0 && i_tx_ready) begin
                i_send_valid = 1'b1;
                i_send_data = (rem == 1) ? 8'h0A : 8'h31;
                rem = rem - 1;
            end else begin
                i_send_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        else passed++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_start(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (o_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (!o_busy) break;
            @(negedge clk);
        end
        chk("wait_idle_busy", 32'(o_busy), 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] req, input logic tm, input logic [31:0] td,
                                input logic [31:0] sd, input logic [31:0] dd, input logic [2:0] eg,
                                input logic [1:0] em, input logic [31:0] ed);
        vec_t v;
        v.req = req; v.time_mode = tm; v.time_d = td; v.sr04_d = sd; v.dht_d = dd;
        v.exp_grant = eg; v.exp_mode = em; v.exp_data = ed;
        return v;
    endfunction

    initial begin
        bit          ok;
        int          s0, s1, s2, s3, prev, cnt, bad;
        logic [2:0]  exp_g [3];
        logic [1:0]  exp_m [3];
        logic [31:0] exp_d [3];

        clk = 1'b0; rst = 1'b0; i_req = '0; i_time_mode = 1'b0;
        i_time_data = '0; i_sr04_data = '0; i_dht_data = '0;
        i_auto_en = 1'b0; i_auto_mask = '0; i_tx_ready = 1'b1;

        vecs[0] = mk(3'b010, 1'b0, 32'h1122_3344, 32'h0000_0400, 32'h0000_5566, 3'b010, 2'd2, 32'h0000_0400);
        vecs[1] = mk(3'b001, 1'b0, 32'h1234_5678, 32'h0000_0400, 32'h0000_5566, 3'b001, 2'd0, 32'h1234_5678);
        vecs[2] = mk(3'b001, 1'b1, 32'h0001_0203, 32'h0000_0400, 32'h0000_5566, 3'b001, 2'd1, 32'h0001_0203);
        vecs[3] = mk(3'b100, 1'b1, 32'h0001_0203, 32'h0000_0400, 32'h0045_0023, 3'b100, 2'd3, 32'h0045_0023);

        // Reset values
        step(3);
        chk("rst_c_mode", 32'(o_c_mode), 32'd0);
        chk("rst_start", 32'(o_start), 32'd0);
        chk("rst_dec_data", o_dec_data, 32'd0);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        rst = 1'b1;
        step(2);

        // Single-source frames with timing
        for (int v = 0; v < 4; v++) begin
            i_req = vecs[v].req; i_time_mode = vecs[v].time_mode;
            i_time_data = vecs[v].time_d; i_sr04_data = vecs[v].sr04_d; i_dht_data = vecs[v].dht_d;
            step(1);
            i_req = '0;
            step(1);
            chk("vec_busy_arb", 32'(o_busy), 32'd1);
            chk("vec_start_early", 32'(o_start), 32'd0);
            step(1);
            chk("vec_grant", 32'(o_grant), 32'(vecs[v].exp_grant));
            chk("vec_mode", 32'(o_c_mode), 32'(vecs[v].exp_mode));
            chk("vec_data", o_dec_data, vecs[v].exp_data);
            chk("vec_start_not_yet", 32'(o_start), 32'd0);
            step(1);
            chk("vec_start_pulse", 32'(o_start), 32'd1);
            step(NB);
            chk("vec_busy_before_lf", 32'(o_busy), 32'd1);
            step(1);
            chk("vec_busy_after_lf", 32'(o_busy), 32'd0);
            chk("vec_grant_after_lf", 32'(o_grant), 32'd0);
            step(2);
        end

        // All three at once: round-robin order from reset-style last grant of DHT
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        exp_m[0] = 2'd1;   exp_m[1] = 2'd2;   exp_m[2] = 2'd3;
        exp_d[0] = 32'h0001_0203; exp_d[1] = 32'h0000_0400; exp_d[2] = 32'h0045_0023;
        i_req = 3'b111;
        step(1);
        i_req = '0;
        for (int g = 0; g < 3; g++) begin
            wait_start(40, ok);
            chk("all3_start_seen", 32'(ok), 32'd1);
            chk("all3_grant", 32'(o_grant), 32'(exp_g[g]));
            chk("all3_mode", 32'(o_c_mode), 32'(exp_m[g]));
            chk("all3_data", o_dec_data, exp_d[g]);
            if (g > 0) chk("all3_gap_ok", 32'((cyc - lf_cyc) >= 4), 32'd1);
        end
        wait_idle(20);
        step(2);

        // Round-robin with re-arm during an in-flight frame, and coalescing
        i_req = 3'b001;
        step(1);
        i_req = '0;
        wait_start(10, ok);
        chk("rr_first_seen", 32'(ok), 32'd1);
        chk("rr_first_grant", 32'(o_grant), 32'b001);
        step(1);
        i_req = 3'b011;
        step(1);
        i_req = '0;
        wait_start(30, ok);
        chk("rr_second_grant", 32'(o_grant), 32'b010);
        wait_start(30, ok);
        chk("rr_third_grant", 32'(o_grant), 32'b001);
        i_req = 3'b100;
        step(3);
        i_req = '0;
        wait_start(30, ok);
        chk("coalesce_grant", 32'(o_grant), 32'b100);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (o_start) cnt++;
        end
        chk("coalesce_no_extra", 32'(cnt), 32'd0);
        wait_idle(20);
        step(2);

        // Back-pressure in START; data latched at grant and held
        i_tx_ready = 1'b0;
        i_req = 3'b010;
        i_sr04_data = 32'h0000_AAAA;
        step(1);
        i_req = '0;
        i_sr04_data = 32'h0000_0BBB;
        step(2);
        chk("bp_grant", 32'(o_grant), 32'b010);
        chk("bp_data_at_grant", o_dec_data, 32'h0000_0BBB);
        i_sr04_data = 32'h0000_CCCC;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (o_start !== 1'b0 || o_dec_data !== 32'h0000_0BBB) bad++;
        end
        chk("bp_hold", 32'(bad), 32'd0);
        i_tx_ready = 1'b1;
        step(1);
        chk("bp_start_once", 32'(o_start), 32'd1);
        step(1);
        chk("bp_start_drop", 32'(o_start), 32'd0);
        wait_idle(20);
        chk("bp_data_held", o_dec_data, 32'h0000_0BBB);
        step(2);

        // Auto-report timer: one DHT frame per 20 cycles
        i_auto_mask = 3'b100;
        i_auto_en = 1'b1;
        wait_start(40, ok);
        s0 = cyc;
        chk("auto_first_seen", 32'(ok), 32'd1);
        chk("auto_grant", 32'(o_grant), 32'b100);
        chk("auto_mode", 32'(o_c_mode), 32'd3);
        wait_start(40, ok);
        s1 = cyc;
        chk("auto_period1", 32'(s1 - s0), 32'd20);
        wait_start(40, ok);
        s2 = cyc;
        chk("auto_period2", 32'(s2 - s1), 32'd20);
        i_auto_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (o_start) cnt++;
        end
        chk("auto_disabled", 32'(cnt), 32'd0);
        i_auto_en = 1'b1;
        wait_start(40, ok);
        s3 = cyc;
        chk("auto_reenable_seen", 32'(ok), 32'd1);
        chk("auto_phase_kept", 32'((s3 - s0) % 20), 32'd0);
        i_auto_en = 1'b0;
        wait_idle(20);
        step(25);

        // Timeout: no LF, ready-only counting
        lf_en = 1'b0;
        i_req = 3'b001;
        step(1);
        i_req = '0;
        wait_start(10, ok);
        chk("to_start_seen", 32'(ok), 32'd1);
        step(10);
        i_tx_ready = 1'b0;
        step(5);
        i_tx_ready = 1'b1;
        step(53);
        chk("to_not_yet", 32'(o_timeout), 32'd0);
        chk("to_busy_before", 32'(o_busy), 32'd1);
        step(1);
        chk("to_pulse", 32'(o_timeout), 32'd1);
        chk("to_busy_after", 32'(o_busy), 32'd0);
        chk("to_grant_after", 32'(o_grant), 32'd0);
        step(1);
        chk("to_pulse_end", 32'(o_timeout), 32'd0);
        step(2);

        // Asynchronous reset in the middle of a frame with another request pending
        i_sr04_data = 32'h0000_0777;
        i_req = 3'b010;
        step(1);
        i_req = '0;
        wait_start(10, ok);
        step(3);
        i_req = 3'b001;
        step(1);
        i_req = '0;
        step(2);
        prev = cyc;
        #2 rst = 1'b0;
        #1;
        chk("arst_no_edge", 32'(cyc - prev), 32'd0);
        chk("arst_c_mode", 32'(o_c_mode), 32'd0);
        chk("arst_dec_data", o_dec_data, 32'd0);
        chk("arst_grant", 32'(o_grant), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_start", 32'(o_start), 32'd0);
        step(1);
        rst = 1'b1;
        lf_en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (o_start || o_busy) cnt++;
        end
        chk("arst_pending_cleared", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
